fetch_sequencer: RTL and testbench

Front-end fetch controller that owns the fetch PC and sequences I-cache line requests, one outstanding at a time. Each returned 128-bit line goes through the instr_aligner datapath and is presented to the instruction buffer as a registered fetch group (4-slot instruction vector plus valid mask). Backend/BPU redirects are absorbed at any point, including killing an in-flight response. Sits between the PC source and the I-cache on one side and the instruction buffer on the other.

---
 rtl/fetch_sequencer_pkg.sv | 35 +++
 rtl/fetch_sequencer_aligner.sv | 22 ++
 rtl/fetch_sequencer.sv | 100 ++++++++++
 tb/tb_fetch_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end definitions: fetch FSM states, line geometry and
// slot-valid masks for the four word alignments inside a fetch line.
`ifndef ICACHE_FETCHWIDTH128_RANGE
`define ICACHE_FETCHWIDTH128_RANGE 127:0
`endif

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  typedef logic [`ICACHE_FETCHWIDTH128_RANGE] line_t;

  localparam int          FETCH_LINE_BYTES = 16;
  localparam logic [63:0] RESET_PC         = 64'h8000_0000;

  localparam logic [3:0] MASK_OFF0 = 4'b1111;
  localparam logic [3:0] MASK_OFF1 = 4'b0111;
  localparam logic [3:0] MASK_OFF2 = 4'b0011;
  localparam logic [3:0] MASK_OFF3 = 4'b0001;

  function automatic logic [3:0] align_mask(input logic [1:0] offset);
    case (offset)
      2'd0:    align_mask = MASK_OFF0;
      2'd1:    align_mask = MASK_OFF1;
      2'd2:    align_mask = MASK_OFF2;
      default: align_mask = MASK_OFF3;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer_aligner.sv
// Instruction aligner: shifts a fetched line so the word at the fetch PC
// lands in slot 0, zero-filling the vacated upper slots.
module instr_aligner
  import fetch_sequencer_pkg::*;
(
  input  line_t      data,
  input  logic [1:0] offset,
  input  logic       pc_operation_done,
  output line_t      instr,
  output logic [3:0] mask
);

  always_comb begin
    instr = '0;
    mask  = '0;
    if (pc_operation_done) begin
      instr = data >> {offset, 5'b0};
      mask  = align_mask(offset);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: issues one I-cache line request at a time, aligns the
// returned line and holds it as a fetch group until the buffer accepts it.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_target,
  output logic         icache_req_valid,
  input  logic         icache_req_ready,
  output logic [63:0]  icache_req_addr,
  input  logic         icache_resp_valid,
  input  line_t        icache_resp_data,
  output logic         fetch_group_valid,
  input  logic         fetch_group_ready,
  output line_t        fetch_group_instr,
  output logic [3:0]   fetch_group_mask,
  output logic [63:0]  fetch_group_pc,
  output fetch_state_e fsm_state
);

  // Handshakes: a transfer happens on a clock edge where valid && ready;
  // valid never depends combinationally on ready or any other input.

  fetch_state_e state;
  logic [63:0]  pc;
  logic         drop;
  line_t        aligned;
  logic [3:0]   aligned_mask;
  logic [63:0]  next_line;

  instr_aligner u_aligner (
    .data              (icache_resp_data),
    .offset            (pc[3:2]),
    .pc_operation_done (1'b1),
    .instr             (aligned),
    .mask              (aligned_mask)
  );

  assign icache_req_addr   = {pc[63:4], 4'b0};
  assign next_line         = icache_req_addr + 64'(FETCH_LINE_BYTES);
  assign icache_req_valid  = (state == ST_REQ);
  assign fetch_group_valid = (state == ST_HOLD);
  assign fsm_state         = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      pc                <= RESET_PC;
      drop              <= 1'b0;
      fetch_group_instr <= '0;
      fetch_group_mask  <= '0;
      fetch_group_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          if (redirect_valid) pc <= redirect_target;
        end
        ST_REQ: begin
          if (redirect_valid) pc <= redirect_target;
          // A redirect racing an accepted request leaves a stale line in flight.
          if (icache_req_ready) begin
            state <= ST_WAIT;
            drop  <= redirect_valid;
          end
        end
        ST_WAIT: begin
          if (icache_resp_valid) begin
            drop  <= 1'b0;
            state <= ST_REQ;
            if (redirect_valid) begin
              pc <= redirect_target;
            end else if (!drop) begin
              fetch_group_instr <= aligned;
              fetch_group_mask  <= aligned_mask;
              fetch_group_pc    <= pc;
              state             <= ST_HOLD;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_target;
            drop <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc    <= redirect_target;
            state <= ST_REQ;
          end else if (fetch_group_ready) begin
            pc    <= next_line;
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus
// hand-written reset-in-flight sequence.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         redirect_valid;
  logic [63:0]  redirect_target;
  logic         icache_req_valid;
  logic         icache_req_ready;
  logic [63:0]  icache_req_addr;
  logic         icache_resp_valid;
  line_t        icache_resp_data;
  logic         fetch_group_valid;
  logic         fetch_group_ready;
  line_t        fetch_group_instr;
  logic [3:0]   fetch_group_mask;
  logic [63:0]  fetch_group_pc;
  fetch_state_e fsm_state;

  int checks = 0;
  int errors = 0;

  fetch_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .fetch_group_valid (fetch_group_valid),
    .fetch_group_ready (fetch_group_ready),
    .fetch_group_instr (fetch_group_instr),
    .fetch_group_mask  (fetch_group_mask),
    .fetch_group_pc    (fetch_group_pc),
    .fsm_state         (fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    fetch_state_e st;
    logic         rv;
    logic [63:0]  tgt;
    logic         rq_rdy;
    logic         rsp_v;
    line_t        data;
    logic         g_rdy;
    logic [63:0]  e_addr;
    logic [3:0]   e_mask;
    logic [63:0]  e_gpc;
    line_t        e_instr;
  } vec_t;

  vec_t  tbl[$];
  line_t ln[8];
  localparam line_t Z = '0;

  function automatic vec_t mk(fetch_state_e st, logic rv, logic [63:0] tgt,
                              logic rq_rdy, logic rsp_v, line_t data, logic g_rdy,
                              logic [63:0] e_addr, logic [3:0] e_mask,
                              logic [63:0] e_gpc, line_t e_instr);
    vec_t v;
    v.st = st; v.rv = rv; v.tgt = tgt; v.rq_rdy = rq_rdy; v.rsp_v = rsp_v;
    v.data = data; v.g_rdy = g_rdy; v.e_addr = e_addr; v.e_mask = e_mask;
    v.e_gpc = e_gpc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver + scoreboard for one cycle: drive at negedge, compare 1ns later
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clock);
    redirect_valid    = v.rv;
    redirect_target   = v.tgt;
    icache_req_ready  = v.rq_rdy;
    icache_resp_valid = v.rsp_v;
    icache_resp_data  = v.data;
    fetch_group_ready = v.g_rdy;
    #1;
    chk({tag, "_state"}, 128'(fsm_state), 128'(v.st));
    chk({tag, "_req_valid"}, 128'(icache_req_valid), 128'(v.st == ST_REQ));
    chk({tag, "_grp_valid"}, 128'(fetch_group_valid), 128'(v.st == ST_HOLD));
    if (v.st == ST_REQ) chk({tag, "_req_addr"}, 128'(icache_req_addr), 128'(v.e_addr));
    if (v.st == ST_HOLD) begin
      chk({tag, "_mask"}, 128'(fetch_group_mask), 128'(v.e_mask));
      chk({tag, "_gpc"}, 128'(fetch_group_pc), 128'(v.e_gpc));
      chk({tag, "_instr"}, fetch_group_instr, v.e_instr);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_state"}, 128'(fsm_state), 128'(ST_IDLE));
    chk({tag, "_req_valid"}, 128'(icache_req_valid), 128'd0);
    chk({tag, "_req_addr"}, 128'(icache_req_addr), 128'h8000_0000);
    chk({tag, "_grp_valid"}, 128'(fetch_group_valid), 128'd0);
    chk({tag, "_instr"}, fetch_group_instr, 128'd0);
    chk({tag, "_mask"}, 128'(fetch_group_mask), 128'd0);
    chk({tag, "_gpc"}, 128'(fetch_group_pc), 128'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      logic [15:0] t;
      t = 16'hA000 + 16'(i * 16'h0111);
      ln[i] = {t, 16'd3, t, 16'd2, t, 16'd1, t, 16'd0};
    end

    // streaming at full rate from RESET_PC
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h8000_0000, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[0], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b1111, 64'h8000_0000, ln[0]));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h8000_0010, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[1], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b1111, 64'h8000_0010, ln[1]));
    // redirect in REQ without handshake
    tbl.push_back(mk(ST_REQ,  1, 64'h8000_0108, 0, 0, Z, 0, 64'h8000_0020, 0, 0, Z));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h8000_0100, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[2], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b0011, 64'h8000_0108, {64'h0, ln[2][127:64]}));
    tbl.push_back(mk(ST_REQ,  0, 0, 0, 0, Z,     0, 64'h8000_0110, 0, 0, Z));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h8000_0110, 0, 0, Z));
    // redirect in WAIT, stale response three cycles later
    tbl.push_back(mk(ST_WAIT, 1, 64'h1004, 0, 0, Z, 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 0, Z,     0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 0, Z,     0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[3], 1, 0, 0, 0, Z));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     1, 64'h1000, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[4], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b0111, 64'h1004, {32'h0, ln[4][127:32]}));
    // redirect on the same cycle as the response
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h1010, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 1, 64'h2008, 0, 1, ln[5], 1, 0, 0, 0, Z));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     1, 64'h2000, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[6], 0, 0, 0, 0, Z));
    // buffer back-pressure for five cycles, stray response ignored
    tbl.push_back(mk(ST_HOLD, 0, 0, 1, 0, Z,     0, 0, 4'b0011, 64'h2008, {64'h0, ln[6][127:64]}));
    tbl.push_back(mk(ST_HOLD, 0, 0, 1, 0, Z,     0, 0, 4'b0011, 64'h2008, {64'h0, ln[6][127:64]}));
    tbl.push_back(mk(ST_HOLD, 0, 0, 1, 1, ln[7], 0, 0, 4'b0011, 64'h2008, {64'h0, ln[6][127:64]}));
    tbl.push_back(mk(ST_HOLD, 0, 0, 1, 0, Z,     0, 0, 4'b0011, 64'h2008, {64'h0, ln[6][127:64]}));
    tbl.push_back(mk(ST_HOLD, 0, 0, 1, 0, Z,     0, 0, 4'b0011, 64'h2008, {64'h0, ln[6][127:64]}));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b0011, 64'h2008, {64'h0, ln[6][127:64]}));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h2010, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[7], 0, 0, 0, 0, Z));
    // redirect in HOLD with ready high: target wins over +16
    tbl.push_back(mk(ST_HOLD, 1, 64'h3000, 0, 0, Z, 1, 0, 4'b1111, 64'h2010, ln[7]));
    // redirect with request handshake: in-flight response is dropped
    tbl.push_back(mk(ST_REQ,  1, 64'h400C, 1, 0, Z, 0, 64'h3000, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[0], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h4000, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[1], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b0001, 64'h400C, {96'h0, ln[1][127:96]}));
    // PC wrap at the top of the address space
    tbl.push_back(mk(ST_REQ,  1, 64'hFFFF_FFFF_FFFF_FFF4, 0, 0, Z, 0, 64'h4010, 0, 0, Z));
    tbl.push_back(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, Z));
    tbl.push_back(mk(ST_WAIT, 0, 0, 0, 1, ln[2], 0, 0, 0, 0, Z));
    tbl.push_back(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b0111, 64'hFFFF_FFFF_FFFF_FFF4, {32'h0, ln[2][127:32]}));
    tbl.push_back(mk(ST_REQ,  0, 0, 0, 0, Z,     0, 64'h0, 0, 0, Z));

    reset             = 1'b1;
    redirect_valid    = 1'b0;
    redirect_target   = '0;
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    icache_resp_data  = '0;
    fetch_group_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // reset asserted while a request is outstanding
    run_vec(mk(ST_REQ, 0, 0, 1, 0, Z, 0, 64'h0, 0, 0, Z), "rst_a");
    @(negedge clock);
    icache_req_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_state("rst_async");
    @(negedge clock);
    reset             = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = ln[5];
    run_vec(mk(ST_REQ,  0, 0, 0, 1, ln[6], 0, 64'h8000_0000, 0, 0, Z), "rst_b");
    run_vec(mk(ST_REQ,  0, 0, 1, 0, Z,     0, 64'h8000_0000, 0, 0, Z), "rst_c");
    run_vec(mk(ST_WAIT, 0, 0, 0, 1, ln[3], 0, 0, 0, 0, Z), "rst_d");
    run_vec(mk(ST_HOLD, 0, 0, 0, 0, Z,     1, 0, 4'b1111, 64'h8000_0000, ln[3]), "rst_e");
    run_vec(mk(ST_REQ,  0, 0, 0, 0, Z,     0, 64'h8000_0010, 0, 0, Z), "rst_f");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
